// File: rtl/writeback_serializer.sv
// Write-back serializer: takes one retiring instruction's E/M result pair
// and issues it to the single register file write port, E first then M.
// Pending (issued-but-not-yet-retired-from-here) writes are visible to
// decode through a combinational forwarding lookup.
module writeback_serializer #(
  parameter int                  DATA_WID = 64,
  parameter int                  ADDR_WID = 4,
  parameter logic [ADDR_WID-1:0] RNONE    = {ADDR_WID{1'b1}},
  parameter int                  CNT_WID  = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_WID-1:0] in_destE,
  input  logic [DATA_WID-1:0] in_valE,
  input  logic [ADDR_WID-1:0] in_destM,
  input  logic [DATA_WID-1:0] in_valM,
  output logic                wr_en,
  output logic [ADDR_WID-1:0] wr_addr,
  output logic [DATA_WID-1:0] wr_data,
  input  logic [ADDR_WID-1:0] fwd_src,
  output logic                fwd_hit,
  output logic [DATA_WID-1:0] fwd_data,
  output logic                busy,
  output logic [CNT_WID-1:0]  wb_count
);

  typedef enum logic [1:0] {IDLE, WR_E, WR_M} state_t;

  state_t              state;
  logic [ADDR_WID-1:0] dest_e_l;
  logic [ADDR_WID-1:0] dest_m_l;
  logic [DATA_WID-1:0] val_e_l;
  logic [DATA_WID-1:0] val_m_l;
  logic                xfer;
  logic                m_follows;

  // E-phase with an M write still owed blocks the producer; any final write cycle accepts
  assign m_follows = (state == WR_E) && (dest_m_l != RNONE);
  assign in_ready  = !m_follows;
  assign xfer      = in_valid && in_ready;
  assign busy      = (state != IDLE);

  // Sequencer: state, latched pair, registered write port and write counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wb_count <= '0;
      dest_e_l <= RNONE;
      dest_m_l <= RNONE;
      val_e_l  <= '0;
      val_m_l  <= '0;
    end else begin
      if (wr_en) wb_count <= wb_count + 1'b1;

      if (m_follows) begin
        state   <= WR_M;
        wr_en   <= 1'b1;
        wr_addr <= dest_m_l;
        wr_data <= val_m_l;
      end else if (xfer) begin
        dest_e_l <= in_destE;
        val_e_l  <= in_valE;
        dest_m_l <= in_destM;
        val_m_l  <= in_valM;
        if (in_destE != RNONE) begin
          state   <= WR_E;
          wr_en   <= 1'b1;
          wr_addr <= in_destE;
          wr_data <= in_valE;
        end else if (in_destM != RNONE) begin
          state   <= WR_M;
          wr_en   <= 1'b1;
          wr_addr <= in_destM;
          wr_data <= in_valM;
        end else begin
          // Instruction retires with nothing to write; leave no stale pending entries
          state    <= IDLE;
          wr_en    <= 1'b0;
          dest_e_l <= RNONE;
          dest_m_l <= RNONE;
          val_e_l  <= '0;
          val_m_l  <= '0;
        end
      end else begin
        state <= IDLE;
        wr_en <= 1'b0;
      end
    end
  end

  // Forwarding lookup over the pending writes; M is younger so it wins a double match
  always_comb begin
    logic hit_e;
    logic hit_m;
    hit_e    = 1'b0;
    hit_m    = 1'b0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_src != RNONE) begin
      hit_e = (state == WR_E) && (dest_e_l == fwd_src);
      hit_m = (state != IDLE) && (dest_m_l == fwd_src);
    end
    fwd_hit = hit_e || hit_m;
    if (hit_m)      fwd_data = val_m_l;
    else if (hit_e) fwd_data = val_e_l;
  end

endmodule

// File: doc/writeback_serializer.md
Name: writeback_serializer

Overview:
- Write-back end of the Y86 register file path: accepts one retiring instruction's pair of results (destE/valE, destM/valM) through a valid/ready handshake.
- Serializes them onto the register file's single write port: E first, then M, so M wins when both target the same register.
- Tracks not-yet-committed writes and exposes a forwarding lookup for decode.
- Sits between the memory stage and the register file write port.

Parameters:
- DATA_WID, 64, width of register values
- ADDR_WID, 4, width of register identifiers
- RNONE, 4'hF, register id meaning "no write"
- CNT_WID, 16, width of the write counter

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  synchronous reset, active-high
- in_valid  input  1  producer offers an instruction's write pair
- in_ready  output  1  serializer can accept this cycle
- in_destE  input  ADDR_WID  E destination (RNONE = none)
- in_valE  input  DATA_WID  E value
- in_destM  input  ADDR_WID  M destination (RNONE = none)
- in_valM  input  DATA_WID  M value
- wr_en  output  1  register file write strobe
- wr_addr  output  ADDR_WID  register file write address
- wr_data  output  DATA_WID  register file write data
- fwd_src  input  ADDR_WID  register id being looked up by decode
- fwd_hit  output  1  a pending write targets fwd_src
- fwd_data  output  DATA_WID  value of the youngest pending write to fwd_src
- busy  output  1  state != IDLE
- wb_count  output  CNT_WID  count of register writes issued

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST), sampled on the rising edge.
- Reset values:
  - state = IDLE; wr_en = 0; wr_addr = 0; wr_data = 0; busy = 0; wb_count = 0.
  - Latched dest fields = RNONE; latched values = 0; fwd_hit = 0.
- A reset asserted mid-write discards all pending writes; no wr_en is issued in the following cycle.
- Handshake:
  - A transfer occurs on a rising edge where in_valid & in_ready. The in_* fields are latched at that edge.
  - Producer must hold in_* stable while in_valid is high and in_ready is low.
- States: IDLE, WR_E, WR_M.
- Outputs (decoded from state and latched fields, registered-state-driven, no input-to-write-port combinational path):
  - WR_E: wr_en = 1, wr_addr = destE_l, wr_data = valE_l.
  - WR_M: wr_en = 1, wr_addr = destM_l, wr_data = valM_l.
  - IDLE: wr_en = 0; wr_addr and wr_data hold their last values.
- in_ready = IDLE | WR_M | (WR_E & destM_l == RNONE). Back-to-back accept during the final write cycle is required, giving zero bubble between instructions.
- Next-state on transfer:
  - in_destE != RNONE -> WR_E.
  - else in_destM != RNONE -> WR_M.
  - else stay/return to IDLE: instruction consumed, no write, latched fields set to RNONE.
- WR_E exit:
  - destM_l != RNONE -> WR_M.
  - else transfer ? (load per rule above) : IDLE.
- WR_M exit: transfer ? (load per rule above) : IDLE.
- Latency: transfer at edge k -> first write presented in cycle k+1, committed by the register file at edge k+1. A two-write instruction occupies cycles k+1 and k+2.
- Same destination for E and M: both writes are issued in order E then M, so the final register value is valM.
- wb_count increments by 1 on every edge where wr_en = 1 and RST = 0; wraps from 2^CNT_WID-1 to 0.
- Forwarding (combinational from fwd_src and state):
  - Pending set: in WR_E = {E, M (if destM_l != RNONE)}; in WR_M = {M}; in IDLE = empty.
  - fwd_hit = 1 iff fwd_src != RNONE and it matches a pending dest.
  - If both E and M match, fwd_data = valM_l; otherwise fwd_data is the matching value.
  - When fwd_hit = 0, fwd_data = 0.
- Inputs with in_valid low are ignored regardless of field contents.

Test Plan:
- Reset then idle: RST high 2 cycles -> wr_en = 0, in_ready = 1, busy = 0, wb_count = 0, fwd_hit = 0 for fwd_src = 4'h0.
- Two-write instruction: transfer destE = 4'h4, valE = 64'h10, destM = 4'h3, valM = 64'h20 -> cycle+1 wr(4, 0x10); cycle+2 wr(3, 0x20); in_ready low in cycle+1; wb_count = 2.
- Same destination: destE = destM = 4'h4, valE = 0x8, valM = 0x99 -> writes 4<-0x8 then 4<-0x99; fwd_src = 4 during WR_E gives fwd_hit = 1, fwd_data = 0x99.
- No-write and E-only streaming: back-to-back in_valid with (F, F), (2, F, valE = 0x5), (1, F, valE = 0x6) -> first consumes with no write; then wr(2, 0x5), wr(1, 0x6) in consecutive cycles, in_ready held high.
- Reset mid-operation: RST asserted during WR_E of a two-write instruction -> next cycle wr_en = 0, state IDLE, wb_count = 0, M write never issued.
- Counter wrap: preload via 65535 E-only writes, then one more -> wb_count wraps to 0.
